// File: rtl/bcd_run_ctrl_pkg.sv
// Shared definitions for the 3-digit BCD run controller: state codes and digit geometry.
package bcd_run_ctrl_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/bcd_run_ctrl_step.sv
// Combinational 3-digit BCD increment/decrement with ripple carry/borrow.
// Latency: 0 cycles (pure combinational); backpressure: none.
module bcd_step
    import bcd_run_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    input  logic             up_dn,
    output logic [BCD_W-1:0] dout
);

    logic [BCD_DIGIT_W-1:0] d;
    logic [BCD_DIGIT_W-1:0] nd;
    logic                   carry;

    // Digits above 9 are treated as wrapping so a bad reload value cannot stick.
    always_comb begin
        dout  = '0;
        carry = 1'b1;
        d     = '0;
        nd    = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            d  = din[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            nd = d;
            if (carry) begin
                if (up_dn) begin
                    if (d >= 4'd9) begin
                        nd = 4'd0;
                    end else begin
                        nd    = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        nd = 4'd9;
                    end else begin
                        nd    = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            dout[i*BCD_DIGIT_W +: BCD_DIGIT_W] = nd;
        end
    end

endmodule

// File: rtl/bcd_run_ctrl.sv
// Start/stop/clear controlled 3-digit BCD up/down counter with terminal detect.
// Latency: tick or button edge to registered outputs in 1 cycle; backpressure: none.
module bcd_run_ctrl
    import bcd_run_ctrl_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_clr,
    input  logic             up_dn,
    input  logic [BCD_W-1:0] limit,
    output logic [3:0]       u,
    output logic [3:0]       t,
    output logic [3:0]       h,
    output logic [1:0]       state,
    output logic             running,
    output logic             done
);

    state_t           st;
    logic             start_q, stop_q, clr_q;
    logic             ev_start, ev_stop, ev_clr;
    logic             win_start, win_stop, win_clr, any_ev;
    logic [BCD_W-1:0] cur, nxt, reload_val;
    logic             terminal;

    assign cur   = {h, t, u};
    assign state = st;

    bcd_step u_step (
        .din   (cur),
        .up_dn (up_dn),
        .dout  (nxt)
    );

    assign ev_start = btn_start & ~start_q;
    assign ev_stop  = btn_stop  & ~stop_q;
    assign ev_clr   = btn_clr   & ~clr_q;

    // Only the highest-priority event acts; any event at all blocks the count step.
    assign win_clr   = ev_clr;
    assign win_stop  = ev_stop & ~ev_clr;
    assign win_start = ev_start & ~ev_stop & ~ev_clr;
    assign any_ev    = ev_start | ev_stop | ev_clr;

    assign reload_val = up_dn ? '0 : limit;
    assign terminal   = up_dn ? (nxt == limit) : (nxt == '0);

    always_ff @(posedge clk1) begin
        if (rst) begin
            {h, t, u} <= '0;
            st        <= ST_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            clr_q     <= 1'b1;
        end else begin
            start_q <= btn_start;
            stop_q  <= btn_stop;
            clr_q   <= btn_clr;
            done    <= 1'b0;
            if (win_clr) begin
                {h, t, u} <= reload_val;
                st        <= ST_IDLE;
                running   <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (win_start) begin
                            st      <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (win_stop) begin
                            st      <= ST_HOLD;
                            running <= 1'b0;
                        end else if (tick && !any_ev) begin
                            if (terminal) begin
                                done <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    {h, t, u} <= reload_val;
                                end else begin
                                    {h, t, u} <= nxt;
                                    st        <= ST_DONE;
                                    running   <= 1'b0;
                                end
                            end else begin
                                {h, t, u} <= nxt;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (win_start) begin
                            st      <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (win_start) begin
                            {h, t, u} <= reload_val;
                            st        <= ST_RUN;
                            running   <= 1'b1;
                        end
                    end
                    default: begin
                        st      <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Directed table-driven bench for bcd_run_ctrl, with a stopping and an auto-reloading instance.
module tb_bcd_run_ctrl;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_stop = 1'b0;
    logic        btn_clr = 1'b0;
    logic        up_dn = 1'b1;
    logic [11:0] limit = 12'h999;

    logic [3:0]  u0, t0, h0, u1, t1, h1;
    logic [1:0]  st0, st1;
    logic        run0, run1, done0, done1;

    int errors = 0;
    int checks = 0;
    int dcnt0  = 0;
    int dcnt1  = 0;

    always #5 clk1 = ~clk1;

    bcd_run_ctrl #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk1(clk1), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_clr(btn_clr), .up_dn(up_dn), .limit(limit),
        .u(u0), .t(t0), .h(h0), .state(st0), .running(run0), .done(done0)
    );

    bcd_run_ctrl #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk1(clk1), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_clr(btn_clr), .up_dn(up_dn), .limit(limit),
        .u(u1), .t(t1), .h(h1), .state(st1), .running(run1), .done(done1)
    );

    typedef struct {
        string       name;
        int          n;
        bit          rs, tk, bs, bp, bc, ud;
        logic [11:0] lim;
        logic [11:0] ed;
        logic [1:0]  es;
        bit          edn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input int n, input bit rs, input bit tk, input bit bs,
                       input bit bp, input bit bc, input bit ud, input logic [11:0] lim,
                       input logic [11:0] ed, input logic [1:0] es, input bit edn);
        vec_t v;
        v.name = nm; v.n = n; v.rs = rs; v.tk = tk; v.bs = bs; v.bp = bp; v.bc = bc;
        v.ud = ud; v.lim = lim; v.ed = ed; v.es = es; v.edn = edn;
        vecs.push_back(v);
    endtask

    task automatic cyc(input bit rs, input bit tk, input bit bs, input bit bp, input bit bc,
                       input bit ud, input logic [11:0] lim);
        rst = rs; tick = tk; btn_start = bs; btn_stop = bp; btn_clr = bc;
        up_dn = ud; limit = lim;
        @(posedge clk1);
        #1;
        dcnt0 += int'(done0);
        dcnt1 += int'(done1);
    endtask

    task automatic check(input string nm, input bit sel, input logic [11:0] ed,
                         input logic [1:0] es, input bit edn);
        logic [15:0] act, exp;
        act = sel ? {h1, t1, u1, st1, run1, done1} : {h0, t0, u0, st0, run0, done0};
        exp = {ed, es, (es == 2'b01), edn};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got digits=%h state=%0d run=%0d done=%0d, want digits=%h state=%0d run=%0d done=%0d",
                     nm, sel, act[15:4], act[3:2], act[1], act[0], exp[15:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_cnt(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d done pulses, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        int base0, base1;
        //     name              n  rs tk bs bp bc ud  limit    digits   st  done
        add("reset",             2, 1, 0, 0, 0, 0, 1, 12'h999, 12'h000, 2'd0, 0);
        add("idle_after_rst",    1, 0, 0, 0, 0, 0, 1, 12'h999, 12'h000, 2'd0, 0);
        add("start_edge",        1, 0, 0, 1, 0, 0, 1, 12'h999, 12'h000, 2'd1, 0);
        add("held_start_12tk",  12, 0, 1, 1, 0, 0, 1, 12'h999, 12'h012, 2'd1, 0);
        add("stop_with_tick",    1, 0, 1, 0, 1, 0, 1, 12'h999, 12'h012, 2'd2, 0);
        add("hold_ignores_tick", 3, 0, 1, 0, 1, 0, 1, 12'h999, 12'h012, 2'd2, 0);
        add("resume",            1, 0, 0, 1, 0, 0, 1, 12'h999, 12'h012, 2'd1, 0);
        add("count_to_047",     35, 0, 1, 1, 0, 0, 1, 12'h999, 12'h047, 2'd1, 0);
        add("release_047",       1, 0, 0, 0, 0, 0, 1, 12'h999, 12'h047, 2'd1, 0);
        add("clr_stop_start",    1, 0, 1, 1, 1, 1, 1, 12'h999, 12'h000, 2'd0, 0);
        add("release_idle",      1, 0, 0, 0, 0, 0, 1, 12'h999, 12'h000, 2'd0, 0);
        add("start_lim015",      1, 0, 0, 1, 0, 0, 1, 12'h015, 12'h000, 2'd1, 0);
        add("up_14",            14, 0, 1, 0, 0, 0, 1, 12'h015, 12'h014, 2'd1, 0);
        add("up_term_015",       1, 0, 1, 0, 0, 0, 1, 12'h015, 12'h015, 2'd3, 1);
        add("done_frozen",       3, 0, 1, 0, 0, 0, 1, 12'h015, 12'h015, 2'd3, 0);
        add("done_stop_ign",     1, 0, 0, 0, 1, 0, 1, 12'h015, 12'h015, 2'd3, 0);
        add("done_release",      1, 0, 0, 0, 0, 0, 1, 12'h015, 12'h015, 2'd3, 0);
        add("clr_dn_lim010",     1, 0, 0, 0, 0, 1, 0, 12'h010, 12'h010, 2'd0, 0);
        add("start_dn",          1, 0, 0, 1, 0, 0, 0, 12'h010, 12'h010, 2'd1, 0);
        add("dn_9",              9, 0, 1, 0, 0, 0, 0, 12'h010, 12'h001, 2'd1, 0);
        add("dn_term_000",       1, 0, 1, 0, 0, 0, 0, 12'h010, 12'h000, 2'd3, 1);
        add("done_start_reload", 1, 0, 0, 1, 0, 0, 0, 12'h010, 12'h010, 2'd1, 0);
        add("clr_up_000",        1, 0, 0, 0, 0, 1, 1, 12'h999, 12'h000, 2'd0, 0);
        add("start_again",       1, 0, 0, 1, 0, 0, 1, 12'h999, 12'h000, 2'd1, 0);
        add("dn_000_to_999",     1, 0, 1, 0, 0, 0, 0, 12'h999, 12'h999, 2'd1, 0);
        add("up_999_to_000",     1, 0, 1, 0, 0, 0, 1, 12'h999, 12'h000, 2'd1, 0);
        add("up_to_100",       100, 0, 1, 0, 0, 0, 1, 12'h999, 12'h100, 2'd1, 0);
        add("dn_100_to_099",     1, 0, 1, 0, 0, 0, 0, 12'h999, 12'h099, 2'd1, 0);
        add("bad_limit_wrap",  901, 0, 1, 0, 0, 0, 1, 12'hFFF, 12'h000, 2'd1, 0);
        add("rst_overrides",     1, 1, 1, 1, 0, 1, 1, 12'h999, 12'h000, 2'd0, 0);
        add("start_held_rst",    3, 0, 0, 1, 0, 0, 1, 12'h999, 12'h000, 2'd0, 0);
        add("start_low",         1, 0, 0, 0, 0, 0, 1, 12'h999, 12'h000, 2'd0, 0);
        add("start_toggle",      1, 0, 0, 1, 0, 0, 1, 12'h999, 12'h000, 2'd1, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++)
                cyc(vecs[i].rs, vecs[i].tk, vecs[i].bs, vecs[i].bp, vecs[i].bc, vecs[i].ud, vecs[i].lim);
            if (vecs[i].name == "reset") begin
                dcnt0 = 0;
                dcnt1 = 0;
            end
            check(vecs[i].name, 1'b0, vecs[i].ed, vecs[i].es, vecs[i].edn);
            if (vecs[i].name == "count_to_047")
                check_cnt("no_done_while_counting", dcnt0, 0);
        end
        check_cnt("table_done_pulses", dcnt0, 2);

        // Down count to terminal on both builds: one stops, the other reloads and keeps running.
        cyc(1, 0, 0, 0, 0, 0, 12'h010);
        cyc(1, 0, 0, 0, 0, 0, 12'h010);
        cyc(0, 0, 0, 0, 0, 0, 12'h010);
        base0 = dcnt0;
        base1 = dcnt1;
        cyc(0, 0, 0, 0, 1, 0, 12'h010);
        check("ar_clr_load", 1'b1, 12'h010, 2'd0, 0);
        cyc(0, 0, 1, 0, 0, 0, 12'h010);
        for (int k = 0; k < 9; k++) cyc(0, 1, 0, 0, 0, 0, 12'h010);
        check("ar_dn_001", 1'b1, 12'h001, 2'd1, 0);
        cyc(0, 1, 0, 0, 0, 0, 12'h010);
        check("nr_term", 1'b0, 12'h000, 2'd3, 1);
        check("ar_term_reload", 1'b1, 12'h010, 2'd1, 1);
        cyc(0, 1, 0, 0, 0, 0, 12'h010);
        check("nr_after_term", 1'b0, 12'h000, 2'd3, 0);
        check("ar_after_reload", 1'b1, 12'h009, 2'd1, 0);
        check_cnt("nr_single_pulse", dcnt0 - base0, 1);
        check_cnt("ar_single_pulse", dcnt1 - base1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_run_ctrl.md
BCD_RUN_CTRL -- requirements
Module: bcd_run_ctrl

Interface
REQ-001 Parameter AUTO_RELOAD, default 0: 1 = on reaching terminal value, reload and keep running instead of stopping.
REQ-002 clk1  input  1  Block clock; all state changes on rising edge.
REQ-003 rst  input  1  Reset, synchronous, active-high; clock clk1.
REQ-004 tick  input  1  Count-enable strobe, one clk1 cycle per count step.
REQ-005 btn_start  input  1  Start/resume request, level, debounced upstream.
REQ-006 btn_stop  input  1  Pause request, level.
REQ-007 btn_clr  input  1  Clear/reload request, level.
REQ-008 up_dn  input  1  Direction: 1 = count up, 0 = count down.
REQ-009 limit  input  12  Terminal value, BCD {h,t,u}.
REQ-010 u, t, h  output  4 each  Units, tens, hundreds BCD digits, registered.
REQ-011 state  output  2  Current FSM state code.
REQ-012 running  output  1  High only in RUN.
REQ-013 done  output  1  One-cycle pulse on reaching terminal value.

Function
REQ-014 Each button is rising-edge detected internally (current high, previous low); level holding produces exactly one event.
REQ-015 Simultaneous events resolve clr > stop > start; only the winner takes effect that cycle.
REQ-016 States: IDLE=00, RUN=01, HOLD=10, DONE=11.
REQ-017 Reload value: 000 when up_dn=1, limit when up_dn=0; reload samples up_dn/limit in the same cycle.
REQ-018 clr event in any state: reload digits, go IDLE, no done pulse.
REQ-019 IDLE: start -> RUN; stop ignored.
REQ-020 RUN: stop -> HOLD; tick with no winning event -> one count step, result visible on u/t/h the following cycle.
REQ-021 HOLD: start -> RUN; digits frozen; tick ignored.
REQ-022 DONE: digits frozen; start -> reload and RUN; stop ignored.
REQ-023 Count step up: u+1; u 9->0 carries to t; t 9->0 carries to h; 999 -> 000.
REQ-024 Count step down: u-1; u 0->9 borrows from t; t 0->9 borrows from h; 000 -> 999.
REQ-025 Terminal: up when post-step value equals limit; down when post-step value equals 000.
REQ-026 On terminal with AUTO_RELOAD=0: go DONE, done=1 for one cycle.
REQ-027 On terminal with AUTO_RELOAD=1: load reload value instead of post-step value, stay RUN, done=1 for one cycle.
REQ-028 Tick coincident with any winning event: no count step that cycle.
REQ-029 up_dn or limit change during RUN takes effect on the next tick; digits are not reloaded.
REQ-030 limit containing a digit >9 is never matched; up-counting then wraps 999->000 indefinitely.

Reset
REQ-031 rst sampled on clk1: u=t=h=0, state=IDLE, running=0, done=0.
REQ-032 Button edge-history registers reset to 1, so buttons held through reset produce no event.
REQ-033 rst mid-count overrides all inputs that cycle, including tick and buttons.

Structure
REQ-034 Shared package holds state codes (IDLE/RUN/HOLD/DONE), BCD digit width 4, and digit count 3.
REQ-035 One sub-module bcd_step: combinational 3-digit BCD increment/decrement (in 12, up_dn, out 12); FSM, edge detect and registers stay in bcd_run_ctrl.

Verification
REQ-036 Reset, btn_start edge, 12 ticks up, limit=999 -> u/t/h=2/1/0, state=RUN, done never pulses.
REQ-037 up_dn=1, limit=015, start, 15 ticks -> digits 015, single done pulse, state=DONE; further ticks leave 015.
REQ-038 up_dn=0, limit=010, clr then start, 10 ticks -> 000, done pulse; AUTO_RELOAD=1 build instead reloads 010 and stays RUN.
REQ-039 Digits 999 up-tick -> 000; digits 100 down-tick -> 099; digits 000 down-tick with limit 999 -> 999 with no done.
REQ-040 clr+stop+start asserted in the same cycle during RUN at 047 -> IDLE, digits 000, no done; tick coincident with stop -> HOLD, digits unchanged.
REQ-041 btn_start held high through rst deassertion -> state stays IDLE; a toggle low-high is then required to enter RUN.
